// File: rtl/mic_pkg.sv
// mic_pkg: shared constants, FSM state type and sample helpers for the microphone jump detector
package mic_pkg;
  localparam int SAMPLE_W = 32;
  localparam logic [31:0] DEF_THRESH = 32'd4000000;
  localparam logic [31:0] DEF_HYST = 32'd1000000;
  localparam int DEF_HOLDOFF = 12500000;
  typedef enum logic [1:0] {QUIET, ARMED, FIRE, HOLDOFF} state_t;
  function automatic logic [SAMPLE_W-1:0] sat_abs(input logic [SAMPLE_W-1:0] x);
    return x[SAMPLE_W-1] ? ((x == 32'h8000_0000) ? 32'h7FFF_FFFF : -x) : x;
  endfunction
endpackage

// File: rtl/mic_jump_detector_if.sv
// mic_jump_detector_if: show-ahead ADC read handshake between the audio controller and the detector
interface mic_jump_detector_if;
  import mic_pkg::*;
  logic audio_in_available;
  logic [SAMPLE_W-1:0] left_channel_audio_in;
  logic [SAMPLE_W-1:0] right_channel_audio_in;
  logic read_audio_in;
  modport master(output audio_in_available, left_channel_audio_in, right_channel_audio_in, input read_audio_in);
  modport slave(input audio_in_available, left_channel_audio_in, right_channel_audio_in, output read_audio_in);
endinterface

// File: rtl/mic_level_meter.sv
// mic_level_meter: three-stage pipeline producing the windowed mean-absolute level of stereo samples
module mic_level_meter
  import mic_pkg::*;
#(
  parameter int WINDOW_LOG2 = 8,
  parameter logic [31:0] THRESH = DEF_THRESH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_valid,
  input  logic [SAMPLE_W-1:0] i_left,
  input  logic [SAMPLE_W-1:0] i_right,
  output logic [31:0]         o_level,
  output logic                o_loud,
  output logic                o_win_done
);
  localparam int ACC_W = 31 + WINDOW_LOG2;
  logic                r_v1, r_v2;
  logic [SAMPLE_W-1:0] r_l, r_r;
  logic [30:0]         r_m;
  logic [ACC_W-1:0]    r_acc;
  logic [WINDOW_LOG2-1:0] r_cnt;
  logic [32:0]         w_pair;
  logic [ACC_W-1:0]    w_sum;
  logic [31:0]         w_lvl;
  assign w_pair = {1'b0, sat_abs(r_l)} + {1'b0, sat_abs(r_r)};
  assign w_sum  = r_acc + ACC_W'(r_m);
  assign w_lvl  = {1'b0, 31'(w_sum >> WINDOW_LOG2)};
  // S1 captures the pair on its handshake edge, S2 forms the per-pair mean magnitude
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_l  <= '0;
      r_r  <= '0;
      r_m  <= '0;
    end else begin
      r_v1 <= i_valid;
      r_v2 <= r_v1;
      if (i_valid) begin
        r_l <= i_left;
        r_r <= i_right;
      end
      if (r_v1) r_m <= 31'(w_pair >> 1);
    end
  // S3 accumulates; the last sample of a window is folded in directly so level lands 3 cycles after its handshake
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      o_level    <= '0;
      o_loud     <= 1'b0;
      o_win_done <= 1'b0;
    end else begin
      o_win_done <= r_v2 && &r_cnt;
      if (r_v2) begin
        r_cnt <= r_cnt + 1'b1;
        r_acc <= &r_cnt ? '0 : w_sum;
        if (&r_cnt) begin
          o_level <= w_lvl;
          o_loud  <= w_lvl >= THRESH;
        end
      end
    end
endmodule

// File: rtl/mic_jump_detector.sv
// mic_jump_detector: turns loud microphone windows into a single-cycle jump trigger with hysteresis and holdoff
module mic_jump_detector
  import mic_pkg::*;
#(
  parameter int WINDOW_LOG2 = 8,
  parameter logic [31:0] THRESH = DEF_THRESH,
  parameter logic [31:0] HYST = DEF_HYST,
  parameter int MIN_HITS = 2,
  parameter int HOLDOFF_CYCLES = DEF_HOLDOFF
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        enable,
  input  logic        read_enable,
  mic_jump_detector_if.slave aud,
  output logic [31:0] level,
  output logic        loud,
  output logic        jump_pulse
);
  state_t      r_state, w_next;
  logic [3:0]  r_hits, w_hits;
  logic [31:0] r_hold, w_hold;
  logic        w_win_done;
  assign aud.read_audio_in = aud.audio_in_available & read_enable & resetn;
  mic_level_meter #(.WINDOW_LOG2(WINDOW_LOG2), .THRESH(THRESH)) u_meter (
    .clk       (CLOCK_50),
    .rst_n     (resetn),
    .i_valid   (aud.read_audio_in),
    .i_left    (aud.left_channel_audio_in),
    .i_right   (aud.right_channel_audio_in),
    .o_level   (level),
    .o_loud    (loud),
    .o_win_done(w_win_done)
  );
  // FSM, hit counter and holdoff counter registers
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      r_state <= QUIET;
      r_hits  <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_next;
      r_hits  <= w_hits;
      r_hold  <= w_hold;
    end
  // Trigger rules: consecutive loud windows fire once, re-arm only after holdoff and a clearly quiet window
  always_comb begin
    w_next     = r_state;
    w_hits     = r_hits;
    w_hold     = (r_hold == '0) ? '0 : r_hold - 1'b1;
    jump_pulse = 1'b0;
    case (r_state)
      QUIET:
        if (w_win_done && loud) begin
          w_hits = 4'd1;
          w_next = (MIN_HITS == 1) ? FIRE : ARMED;
        end
      ARMED:
        if (w_win_done) begin
          w_hits = loud ? r_hits + 1'b1 : '0;
          w_next = !loud ? QUIET : (w_hits >= 4'(MIN_HITS)) ? FIRE : ARMED;
        end
      FIRE: begin
        jump_pulse = 1'b1;
        w_hold     = 32'(HOLDOFF_CYCLES);
        w_hits     = '0;
        w_next     = HOLDOFF;
      end
      HOLDOFF:
        if (r_hold == '0 && w_win_done && level < THRESH - HYST) w_next = QUIET;
    endcase
    if (!enable) begin
      w_next     = QUIET;
      w_hits     = '0;
      w_hold     = '0;
      jump_pulse = 1'b0;
    end
  end
endmodule

// File: tb/tb_mic_jump_detector.sv
// tb_mic_jump_detector: directed stimulus against a window-level behavioural model checked every cycle
module tb_mic_jump_detector;
  logic clk = 1'b0, resetn = 1'b0, enable = 1'b1, read_enable = 1'b1;
  logic [31:0] level;
  logic loud, jump_pulse;
  mic_jump_detector_if aud();
  mic_jump_detector #(
    .WINDOW_LOG2(2), .THRESH(32'd1000), .HYST(32'd200), .MIN_HITS(2), .HOLDOFF_CYCLES(20)
  ) dut (
    .CLOCK_50(clk), .resetn(resetn), .enable(enable), .read_enable(read_enable),
    .aud(aud), .level(level), .loud(loud), .jump_pulse(jump_pulse)
  );
  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  int pulse_cnt = 0, hs_cnt = 0, last_hs = 0, last_pulse = 0;
  longint win_q[$];
  logic [31:0] lvl_evt[int];
  bit pulse_evt[int];
  logic [31:0] e_level = 0;
  int hits = 0, hold_zero = 0;
  bit in_hold = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  function automatic longint mag(input logic [31:0] x);
    longint v;
    v = longint'($signed(x));
    v = (v < 0) ? -v : v;
    return (v > 64'sd2147483647) ? 64'sd2147483647 : v;
  endfunction

  // A completed window of level e_level becomes visible in cycle c
  task automatic window_event(input int c);
    if (in_hold) begin
      if (c >= hold_zero && e_level < 800) in_hold = 0;
    end else if (e_level >= 1000) begin
      hits++;
      if (hits >= 2) begin
        pulse_evt[c+1] = 1;
        in_hold = 1;
        hold_zero = c + 22;
        hits = 0;
      end
    end else hits = 0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : model
    longint s;
    logic e_read;
    if (!resetn) begin
      win_q.delete();
      lvl_evt.delete();
      pulse_evt.delete();
      e_level = 0;
      hits = 0;
      in_hold = 0;
    end else begin
      if (lvl_evt.exists(cyc)) begin
        e_level = lvl_evt[cyc];
        if (enable) window_event(cyc);
      end
      if (!enable) begin
        hits = 0;
        in_hold = 0;
      end
    end
    e_read = aud.audio_in_available & read_enable & resetn;
    chk("read_audio_in", {31'd0, aud.read_audio_in}, {31'd0, e_read});
    chk("level", level, e_level);
    chk("loud", {31'd0, loud}, {31'd0, e_level >= 1000});
    chk("jump_pulse", {31'd0, jump_pulse}, {31'd0, resetn && enable && pulse_evt.exists(cyc)});
    if (jump_pulse === 1'b1) begin
      pulse_cnt++;
      last_pulse = cyc;
    end
    if (e_read) begin
      hs_cnt++;
      last_hs = cyc;
      win_q.push_back((mag(aud.left_channel_audio_in) + mag(aud.right_channel_audio_in)) / 2);
      if (win_q.size() == 4) begin
        s = 0;
        foreach (win_q[i]) s += win_q[i];
        lvl_evt[cyc+3] = 32'(s / 4);
        win_q.delete();
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic win(input logic [31:0] l, input logic [31:0] r, input int n = 4);
    for (int i = 0; i < n; i++) begin
      aud.audio_in_available = 1'b1;
      aud.left_channel_audio_in = l;
      aud.right_channel_audio_in = r;
      @(posedge clk);
      #1;
    end
    aud.audio_in_available = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin : stim
    int p0, h0;
    aud.audio_in_available = 1'b0;
    aud.left_channel_audio_in = '0;
    aud.right_channel_audio_in = '0;
    idle(3);
    chk("reset_level", level, 32'd0);
    chk("reset_pulse", {31'd0, jump_pulse}, 32'd0);
    resetn = 1'b1;
    // 1: async reset mid-run, then a quiet 500 window
    win(32'd2000, -32'sd2000);
    idle(6);
    chk("t1_pre_level", level, 32'd2000);
    @(posedge clk);
    #1 aud.audio_in_available = 1'b1;
    #2 resetn = 1'b0;
    #1;
    chk("t1_async_read", {31'd0, aud.read_audio_in}, 32'd0);
    chk("t1_async_level", level, 32'd0);
    chk("t1_async_loud", {31'd0, loud}, 32'd0);
    aud.audio_in_available = 1'b0;
    idle(2);
    resetn = 1'b1;
    win(32'd500, 32'd500);
    idle(6);
    chk("t1_level", level, 32'd500);
    chk("t1_loud", {31'd0, loud}, 32'd0);
    chk("t1_pulses", 32'(pulse_cnt), 32'd0);
    // 2: two loud windows fire once, 4 cycles after the 8th handshake
    p0 = pulse_cnt;
    win(32'd2000, -32'sd2000, 8);
    idle(8);
    chk("t2_level", level, 32'd2000);
    chk("t2_pulses", 32'(pulse_cnt - p0), 32'd1);
    chk("t2_latency", 32'(last_pulse - last_hs), 32'd4);
    idle(25);
    win(32'd300, 32'd300);
    idle(6);
    // 4: loud/quiet alternation never fires (1000 is loud at the boundary)
    p0 = pulse_cnt;
    win(32'd2000, -32'sd2000);
    win(32'd300, 32'd300);
    win(32'd1000, 32'd1000);
    win(32'd300, 32'd300);
    win(32'd2000, -32'sd2000);
    win(32'd300, 32'd300);
    idle(6);
    chk("t4_pulses", 32'(pulse_cnt - p0), 32'd0);
    chk("t4_level", level, 32'd300);
    // 3: most negative samples saturate
    win(32'h8000_0000, 32'h8000_0000);
    idle(6);
    chk("t3_level", level, 32'h7FFF_FFFF);
    chk("t3_loud", {31'd0, loud}, 32'd1);
    win(32'd300, 32'd300);
    idle(6);
    // 5: sustained sound fires once; hysteresis band holds off; quiet re-arms
    p0 = pulse_cnt;
    win(32'd2000, -32'sd2000, 40);
    idle(6);
    chk("t5_single", 32'(pulse_cnt - p0), 32'd1);
    win(32'd900, 32'd900);
    idle(2);
    win(32'd2000, -32'sd2000, 8);
    idle(6);
    chk("t5_band_holds", 32'(pulse_cnt - p0), 32'd1);
    win(32'd700, 32'd700);
    idle(2);
    win(32'd2000, -32'sd2000, 8);
    idle(6);
    chk("t5_rearm", 32'(pulse_cnt - p0), 32'd2);
    // 6: read_enable low blocks consumption; enable low still meters but never fires
    h0 = hs_cnt;
    read_enable = 1'b0;
    aud.audio_in_available = 1'b1;
    aud.left_channel_audio_in = 32'd100;
    aud.right_channel_audio_in = 32'd100;
    idle(10);
    chk("t6_stall_level", level, 32'd2000);
    chk("t6_stall_hs", 32'(hs_cnt - h0), 32'd0);
    aud.audio_in_available = 1'b0;
    read_enable = 1'b1;
    enable = 1'b0;
    h0 = hs_cnt;
    p0 = pulse_cnt;
    win(32'd3000, -32'sd3000, 12);
    idle(6);
    chk("t6_dis_level", level, 32'd3000);
    chk("t6_dis_loud", {31'd0, loud}, 32'd1);
    chk("t6_dis_hs", 32'(hs_cnt - h0), 32'd12);
    chk("t6_dis_pulses", 32'(pulse_cnt - p0), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
